// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, state type and permutation helpers
package des_pkg;

    localparam int RK_W  = 48;
    localparam int IDX_W = 4;

    typedef enum logic {IDLE, RUN} schedState;

    // Table entries are DES bit numbers: 1 selects the MSB of the source vector.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Encrypt: left-rotate amount entering round n+1.
    localparam logic [1:0] ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Decrypt: right-rotate amount before emitting key n (K16 first, so no shift at 0).
    localparam logic [1:0] DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Bits are shifted in MSB-first, so table entry 0 lands in cd[55].
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd = {cd[54:0], key[6'(64 - PC1[i])]};
        end
        return cd;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    // Every key byte must carry an odd number of ones.
    function automatic logic keyParityOk(input logic [63:0] key);
        return (^key[63:56]) & (^key[55:48]) & (^key[47:40]) & (^key[39:32]) &
               (^key[31:24]) & (^key[23:16]) & (^key[15:8])  & (^key[7:0]);
    endfunction

endpackage

// File: rtl/des_key_sched_if.sv
// rtl/des_key_sched_if.sv - key input and round-key output handshake bundle
interface des_key_sched_if;
    logic [63:0]                  key_i;
    logic                         decrypt_i;
    logic                         key_valid_i;
    logic                         key_ready_o;
    logic [des_pkg::RK_W-1:0]     rk_o;
    logic [des_pkg::IDX_W-1:0]    rk_idx_o;
    logic                         rk_last_o;
    logic                         rk_valid_o;
    logic                         rk_ready_i;
    logic                         parity_err_o;

    modport master (
        output key_i, decrypt_i, key_valid_i, rk_ready_i,
        input  key_ready_o, rk_o, rk_idx_o, rk_last_o, rk_valid_o, parity_err_o
    );

    modport slave (
        input  key_i, decrypt_i, key_valid_i, rk_ready_i,
        output key_ready_o, rk_o, rk_idx_o, rk_last_o, rk_valid_o, parity_err_o
    );
endinterface

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 compression of C||D into a 48-bit round key
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0]     cd,
    output logic [RK_W-1:0] rk
);
    // Select 48 of the 56 C||D bits, first table entry ending up in the MSB.
    always_comb begin
        rk = '0;
        for (int i = 0; i < RK_W; i++) begin
            rk = {rk[RK_W-2:0], cd[6'(56 - PC2[i])]};
        end
    end
endmodule

// File: rtl/des_key_sched.sv
// rtl/des_key_sched.sv - DES round-key schedule engine; DES_KEY_PARITY_CHK_EN enables key parity check
module des_key_sched
    import des_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    des_key_sched_if.slave bus
);
    schedState        state;
    schedState        nextState;
    logic [27:0]      cReg;
    logic [27:0]      dReg;
    logic [IDX_W-1:0] idxReg;
    logic [IDX_W-1:0] idxNext;
    logic             modeReg;
    logic [55:0]      cdLoad;
    logic             keyReady;
    logic             rkValid;
    logic             accept;
    logic             handshake;
    logic             keyGood;
    logic             lastRound;

    assign keyReady  = (state == IDLE);
    assign rkValid   = (state == RUN);
    assign accept    = bus.key_valid_i && keyReady;
    assign handshake = rkValid && bus.rk_ready_i;
    assign lastRound = (idxReg == 4'd15);
    assign idxNext   = idxReg + 4'd1;
    assign cdLoad    = pc1(bus.key_i);

`ifdef DES_KEY_PARITY_CHK_EN
    logic parityErr;

    assign keyGood = keyParityOk(bus.key_i);

    // Pulse for the single cycle after a bad-parity key is offered; the key is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) parityErr <= 1'b0;
        else        parityErr <= accept && !keyGood;
    end

    assign bus.parity_err_o = parityErr;
`else
    assign keyGood          = 1'b1;
    assign bus.parity_err_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Enter RUN on a good key; leave after the consumer takes the 16th round key.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept && keyGood)     nextState = RUN;
            RUN:     if (handshake && lastRound) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Load C/D pre-shifted for the first emitted key, then advance one round per handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cReg    <= '0;
            dReg    <= '0;
            idxReg  <= '0;
            modeReg <= 1'b0;
        end else if (accept && keyGood) begin
            cReg    <= bus.decrypt_i ? rotr28(cdLoad[55:28], DEC_SHIFT[0])
                                     : rotl28(cdLoad[55:28], ENC_SHIFT[0]);
            dReg    <= bus.decrypt_i ? rotr28(cdLoad[27:0], DEC_SHIFT[0])
                                     : rotl28(cdLoad[27:0], ENC_SHIFT[0]);
            idxReg  <= '0;
            modeReg <= bus.decrypt_i;
        end else if (handshake && !lastRound) begin
            cReg   <= modeReg ? rotr28(cReg, DEC_SHIFT[idxNext]) : rotl28(cReg, ENC_SHIFT[idxNext]);
            dReg   <= modeReg ? rotr28(dReg, DEC_SHIFT[idxNext]) : rotl28(dReg, ENC_SHIFT[idxNext]);
            idxReg <= idxNext;
        end
    end

    des_pc2 uPc2 (
        .cd ({cReg, dReg}),
        .rk (bus.rk_o)
    );

    assign bus.key_ready_o = keyReady;
    assign bus.rk_valid_o  = rkValid;
    assign bus.rk_idx_o    = idxReg;
    assign bus.rk_last_o   = rkValid && lastRound;

endmodule

// File: tb/tb_des_key_sched.sv
// tb/tb_des_key_sched.sv - directed-vector bench for des_key_sched
module tb_des_key_sched;

    localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
    localparam logic [63:0] BAD_KEY = 64'h133457799BBCDFF0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    des_key_sched_if ifc ();

    des_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    logic [47:0] expKeys [16];
    logic [47:0] gotRk   [16];
    logic [3:0]  gotIdx  [16];
    logic        gotLast [16];
    int capCount, capCycles, capStallBad, capReadyBad, capGapBad;

    task automatic loadKey(input logic [63:0] k, input logic dec);
        @(negedge clk);
        ifc.key_i       = k;
        ifc.decrypt_i   = dec;
        ifc.key_valid_i = 1'b1;
        @(posedge clk);
        #1 ifc.key_valid_i = 1'b0;
    endtask

    task automatic captureKeys(input bit stall, input bit poke);
        logic [47:0] heldRk;
        logic [3:0]  heldIdx;
        bit          held;
        logic        rdy;
        capCount = 0; capCycles = 0; capStallBad = 0; capReadyBad = 0; capGapBad = 0;
        held = 0; heldRk = '0; heldIdx = '0;
        while (capCount < 16 && capCycles < 500) begin
            @(negedge clk);
            capCycles++;
            if (poke) begin
                ifc.key_valid_i = 1'($urandom_range(0, 1));
                ifc.key_i       = {$urandom, $urandom};
            end
            if (ifc.rk_valid_o !== 1'b1) begin
                capGapBad++;
            end else begin
                if (ifc.key_ready_o !== 1'b0) capReadyBad++;
                if (held && (ifc.rk_o !== heldRk || ifc.rk_idx_o !== heldIdx)) capStallBad++;
                rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                ifc.rk_ready_i = rdy;
                if (rdy) begin
                    gotRk[capCount]   = ifc.rk_o;
                    gotIdx[capCount]  = ifc.rk_idx_o;
                    gotLast[capCount] = ifc.rk_last_o;
                    capCount++;
                    held = 0;
                end else begin
                    held = 1; heldRk = ifc.rk_o; heldIdx = ifc.rk_idx_o;
                end
            end
        end
        @(posedge clk);
        #1;
        ifc.rk_ready_i  = 1'b0;
        ifc.key_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        testsRun++; if (ifc.key_ready_o !== 1'b1) begin testsFailed++; $display("FAIL reset_key_ready got %b exp 1", ifc.key_ready_o); end
        testsRun++; if (ifc.rk_valid_o !== 1'b0) begin testsFailed++; $display("FAIL reset_rk_valid got %b exp 0", ifc.rk_valid_o); end
        testsRun++; if (ifc.rk_o !== 48'h0) begin testsFailed++; $display("FAIL reset_rk got %h exp 0", ifc.rk_o); end
        testsRun++; if (ifc.rk_idx_o !== 4'd0) begin testsFailed++; $display("FAIL reset_idx got %0d exp 0", ifc.rk_idx_o); end
        testsRun++; if (ifc.rk_last_o !== 1'b0) begin testsFailed++; $display("FAIL reset_last got %b exp 0", ifc.rk_last_o); end
        testsRun++; if (ifc.parity_err_o !== 1'b0) begin testsFailed++; $display("FAIL reset_parity got %b exp 0", ifc.parity_err_o); end
    endtask

    task automatic test_encrypt;
        loadKey(KEY, 1'b0);
        captureKeys(1'b0, 1'b0);
        testsRun++; if (capCount != 16) begin testsFailed++; $display("FAIL enc_count got %0d exp 16", capCount); end
        testsRun++; if (capCycles != 16 || capGapBad != 0) begin testsFailed++; $display("FAIL enc_consecutive cycles %0d gaps %0d exp 16/0", capCycles, capGapBad); end
        testsRun++; if (capReadyBad != 0) begin testsFailed++; $display("FAIL enc_key_ready_in_run got %0d exp 0", capReadyBad); end
        for (int i = 0; i < 16; i++) begin
            testsRun++; if (gotRk[i] !== expKeys[i]) begin testsFailed++; $display("FAIL enc_rk[%0d] got %h exp %h", i, gotRk[i], expKeys[i]); end
            testsRun++; if (gotIdx[i] !== 4'(i)) begin testsFailed++; $display("FAIL enc_idx[%0d] got %0d exp %0d", i, gotIdx[i], i); end
            testsRun++; if (gotLast[i] !== (i == 15)) begin testsFailed++; $display("FAIL enc_last[%0d] got %b exp %b", i, gotLast[i], (i == 15)); end
        end
        @(negedge clk);
        testsRun++; if (ifc.key_ready_o !== 1'b1 || ifc.rk_valid_o !== 1'b0) begin testsFailed++; $display("FAIL enc_back_idle ready %b valid %b exp 1/0", ifc.key_ready_o, ifc.rk_valid_o); end
    endtask

    task automatic test_decrypt;
        loadKey(KEY, 1'b1);
        captureKeys(1'b0, 1'b0);
        testsRun++; if (capCount != 16) begin testsFailed++; $display("FAIL dec_count got %0d exp 16", capCount); end
        for (int i = 0; i < 16; i++) begin
            testsRun++; if (gotRk[i] !== expKeys[15-i]) begin testsFailed++; $display("FAIL dec_rk[%0d] got %h exp %h", i, gotRk[i], expKeys[15-i]); end
            testsRun++; if (gotIdx[i] !== 4'(i)) begin testsFailed++; $display("FAIL dec_idx[%0d] got %0d exp %0d", i, gotIdx[i], i); end
            testsRun++; if (gotLast[i] !== (i == 15)) begin testsFailed++; $display("FAIL dec_last[%0d] got %b exp %b", i, gotLast[i], (i == 15)); end
        end
    endtask

    task automatic test_stall;
        loadKey(KEY, 1'b0);
        captureKeys(1'b1, 1'b1);
        testsRun++; if (capCount != 16) begin testsFailed++; $display("FAIL stall_count got %0d exp 16", capCount); end
        testsRun++; if (capStallBad != 0) begin testsFailed++; $display("FAIL stall_stable got %0d changes exp 0", capStallBad); end
        testsRun++; if (capReadyBad != 0) begin testsFailed++; $display("FAIL stall_key_ready got %0d exp 0", capReadyBad); end
        testsRun++; if (capGapBad != 0) begin testsFailed++; $display("FAIL stall_valid_drop got %0d exp 0", capGapBad); end
        for (int i = 0; i < 16; i++) begin
            testsRun++; if (gotRk[i] !== expKeys[i]) begin testsFailed++; $display("FAIL stall_rk[%0d] got %h exp %h", i, gotRk[i], expKeys[i]); end
        end
        @(negedge clk);
        testsRun++; if (ifc.rk_valid_o !== 1'b0) begin testsFailed++; $display("FAIL stall_no_spurious_accept got %b exp 0", ifc.rk_valid_o); end
    endtask

    task automatic test_reset_mid_run;
        bit found;
        found = 0;
        loadKey(KEY, 1'b0);
        ifc.rk_ready_i = 1'b1;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (ifc.rk_valid_o === 1'b1 && ifc.rk_idx_o === 4'd7) found = 1;
        end
        testsRun++; if (!found) begin testsFailed++; $display("FAIL midrst_reach_idx7 got none exp idx 7 within 40 cycles"); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ifc.rk_ready_i = 1'b0;
        @(negedge clk);
        testsRun++; if (ifc.rk_valid_o !== 1'b0) begin testsFailed++; $display("FAIL midrst_valid got %b exp 0", ifc.rk_valid_o); end
        testsRun++; if (ifc.rk_o !== 48'h0) begin testsFailed++; $display("FAIL midrst_rk got %h exp 0", ifc.rk_o); end
        testsRun++; if (ifc.key_ready_o !== 1'b1) begin testsFailed++; $display("FAIL midrst_key_ready got %b exp 1", ifc.key_ready_o); end
        loadKey(KEY, 1'b0);
        @(negedge clk);
        testsRun++; if (ifc.rk_valid_o !== 1'b1 || ifc.rk_idx_o !== 4'd0) begin testsFailed++; $display("FAIL midrst_reload valid %b idx %0d exp 1/0", ifc.rk_valid_o, ifc.rk_idx_o); end
        testsRun++; if (ifc.rk_o !== expKeys[0]) begin testsFailed++; $display("FAIL midrst_reload_rk got %h exp %h", ifc.rk_o, expKeys[0]); end
        captureKeys(1'b0, 1'b0);
        testsRun++; if (capCount != 16 || gotRk[15] !== expKeys[15]) begin testsFailed++; $display("FAIL midrst_rerun count %0d rk15 %h exp 16/%h", capCount, gotRk[15], expKeys[15]); end
    endtask

    task automatic test_parity;
`ifdef DES_KEY_PARITY_CHK_EN
        loadKey(BAD_KEY, 1'b0);
        @(negedge clk);
        testsRun++; if (ifc.parity_err_o !== 1'b1) begin testsFailed++; $display("FAIL parity_err_pulse got %b exp 1", ifc.parity_err_o); end
        testsRun++; if (ifc.rk_valid_o !== 1'b0) begin testsFailed++; $display("FAIL parity_no_valid got %b exp 0", ifc.rk_valid_o); end
        @(negedge clk);
        testsRun++; if (ifc.parity_err_o !== 1'b0) begin testsFailed++; $display("FAIL parity_err_width got %b exp 0", ifc.parity_err_o); end
        testsRun++; if (ifc.rk_valid_o !== 1'b0 || ifc.key_ready_o !== 1'b1) begin testsFailed++; $display("FAIL parity_stay_idle valid %b ready %b exp 0/1", ifc.rk_valid_o, ifc.key_ready_o); end
`else
        loadKey(BAD_KEY, 1'b0);
        @(negedge clk);
        testsRun++; if (ifc.parity_err_o !== 1'b0) begin testsFailed++; $display("FAIL parity_tied_low got %b exp 0", ifc.parity_err_o); end
        testsRun++; if (ifc.rk_valid_o !== 1'b1) begin testsFailed++; $display("FAIL parity_accepted got %b exp 1", ifc.rk_valid_o); end
        captureKeys(1'b0, 1'b0);
        testsRun++; if (capCount != 16) begin testsFailed++; $display("FAIL parity_count got %0d exp 16", capCount); end
        for (int i = 0; i < 16; i++) begin
            testsRun++; if (gotRk[i] !== expKeys[i]) begin testsFailed++; $display("FAIL parity_rk[%0d] got %h exp %h", i, gotRk[i], expKeys[i]); end
        end
`endif
    endtask

    task automatic test_back_to_back;
        int hs;
        int cyc;
        int readyBad;
        hs = 0; cyc = 0; readyBad = 0;
        loadKey(KEY, 1'b0);
        ifc.key_i       = KEY;
        ifc.decrypt_i   = 1'b1;
        ifc.key_valid_i = 1'b1;
        ifc.rk_ready_i  = 1'b1;
        while (hs < 16 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ifc.key_ready_o !== 1'b0) readyBad++;
            if (ifc.rk_valid_o === 1'b1) hs++;
        end
        testsRun++; if (hs != 16 || readyBad != 0) begin testsFailed++; $display("FAIL b2b_first_run hs %0d ready_violations %0d exp 16/0", hs, readyBad); end
        @(negedge clk);
        testsRun++; if (ifc.key_ready_o !== 1'b1 || ifc.rk_valid_o !== 1'b0) begin testsFailed++; $display("FAIL b2b_idle_gap ready %b valid %b exp 1/0", ifc.key_ready_o, ifc.rk_valid_o); end
        @(posedge clk);
        #1;
        ifc.key_valid_i = 1'b0;
        ifc.rk_ready_i  = 1'b0;
        @(negedge clk);
        testsRun++; if (ifc.rk_valid_o !== 1'b1 || ifc.rk_idx_o !== 4'd0) begin testsFailed++; $display("FAIL b2b_second_start valid %b idx %0d exp 1/0", ifc.rk_valid_o, ifc.rk_idx_o); end
        testsRun++; if (ifc.rk_o !== expKeys[15]) begin testsFailed++; $display("FAIL b2b_second_rk0 got %h exp %h", ifc.rk_o, expKeys[15]); end
        captureKeys(1'b0, 1'b0);
        testsRun++; if (capCount != 16 || gotRk[15] !== expKeys[0]) begin testsFailed++; $display("FAIL b2b_second_run count %0d rk15 %h exp 16/%h", capCount, gotRk[15], expKeys[0]); end
    endtask

    initial begin
        expKeys = '{
            48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
            48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
            48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
            48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
        };
        ifc.key_i       = '0;
        ifc.decrypt_i   = 1'b0;
        ifc.key_valid_i = 1'b0;
        ifc.rk_ready_i  = 1'b0;

        test_reset();
        test_encrypt();
        test_decrypt();
        test_stall();
        test_reset_mid_run();
        test_parity();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
